// File: rtl/vx_commit_arbiter_pkg.sv
// Shared definitions for the commit arbiter: requester indices, default geometry and
// payload width helpers.
package vx_commit_arbiter_pkg;

   localparam int unsigned DEF_NUM_REQS    = 5;
   localparam int unsigned DEF_NUM_THREADS = 4;
   localparam int unsigned DEF_NW_BITS     = 2;
   localparam int unsigned DEF_NR_BITS     = 6;

   localparam int unsigned EX_ALU = 0;
   localparam int unsigned EX_LSU = 1;
   localparam int unsigned EX_CSR = 2;
   localparam int unsigned EX_FPU = 3;
   localparam int unsigned EX_GPU = 4;

   // wid + tmask + PC + rd + wb + data
   function automatic int unsigned commit_width(input int unsigned nw, input int unsigned nt,
                                                input int unsigned nr);
      return nw + nt + 32 + nr + 1 + nt * 32;
   endfunction

   function automatic int unsigned idx_bits(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/vx_commit_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer, modulo N.
// The pointer advances past the winner only when the grant is taken (enable).
module vx_commit_arbiter_rr_arbiter
   import vx_commit_arbiter_pkg::*;
#(
   parameter int unsigned N    = 5,
   parameter int unsigned IdxW = idx_bits(N)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N-1:0]    requests,
   input  logic            enable,
   output logic [N-1:0]    grant_onehot,
   output logic [IdxW-1:0] grant_index,
   output logic            grant_valid
);

   logic [IdxW-1:0] ptr_q, ptr_d;
   logic            hi_valid, lo_valid;
   logic [IdxW-1:0] hi_index, lo_index;

   // Descending scan leaves the lowest set index overall (lo) and at/after ptr (hi).
   always_comb begin
      hi_valid = 1'b0;
      hi_index = '0;
      lo_valid = 1'b0;
      lo_index = '0;
      for (int i = int'(N) - 1; i >= 0; i--) begin
         if (requests[i]) begin
            lo_valid = 1'b1;
            lo_index = IdxW'(i);
            if (i >= int'(ptr_q)) begin
               hi_valid = 1'b1;
               hi_index = IdxW'(i);
            end
         end
      end
   end

   assign grant_valid = lo_valid;
   assign grant_index = hi_valid ? hi_index : lo_index;

   always_comb begin
      grant_onehot = '0;
      for (int i = 0; i < int'(N); i++) begin
         grant_onehot[i] = grant_valid && (grant_index == IdxW'(i));
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (enable && grant_valid) begin
         ptr_d = (grant_index == IdxW'(N - 1)) ? '0 : grant_index + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/vx_commit_arbiter.sv
// Shares the GPR commit port between execute units: round-robin grant into a
// main+skid output buffer, plus a stall-cycle performance counter.
module vx_commit_arbiter
   import vx_commit_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQS    = DEF_NUM_REQS,
   parameter int unsigned NUM_THREADS = DEF_NUM_THREADS,
   parameter int unsigned NW_BITS     = DEF_NW_BITS,
   parameter int unsigned NR_BITS     = DEF_NR_BITS,
   parameter int unsigned REQ_BITS    = idx_bits(NUM_REQS)
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_REQS-1:0]             req_valid,
   output logic [NUM_REQS-1:0]             req_ready,
   input  logic [NUM_REQS*NW_BITS-1:0]     req_wid,
   input  logic [NUM_REQS*NUM_THREADS-1:0] req_tmask,
   input  logic [NUM_REQS*32-1:0]          req_PC,
   input  logic [NUM_REQS*NR_BITS-1:0]     req_rd,
   input  logic [NUM_REQS-1:0]             req_wb,
   input  logic [NUM_REQS*NUM_THREADS*32-1:0] req_data,
   output logic                            wb_valid,
   input  logic                            wb_ready,
   output logic [REQ_BITS-1:0]             wb_src,
   output logic [NW_BITS-1:0]              wb_wid,
   output logic [NUM_THREADS-1:0]          wb_tmask,
   output logic [31:0]                     wb_PC,
   output logic [NR_BITS-1:0]              wb_rd,
   output logic                            wb_wb,
   output logic [NUM_THREADS*32-1:0]       wb_data,
   output logic [31:0]                     perf_stalls
);

   localparam int unsigned CW = commit_width(NW_BITS, NUM_THREADS, NR_BITS);
   localparam int unsigned EW = REQ_BITS + CW;
   localparam int unsigned DW = NUM_THREADS * 32;

   logic [NUM_REQS-1:0] grant_onehot;
   logic [REQ_BITS-1:0] grant_index;
   logic                grant_valid;
   logic                accept_en, accept, handshake;
   logic [CW-1:0]       sel_payload;
   logic [EW-1:0]       new_entry;
   logic                main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
   logic [EW-1:0]       main_q, main_d, skid_q, skid_d;
   logic [31:0]         perf_q, perf_d;

   vx_commit_arbiter_rr_arbiter #(
      .N    (NUM_REQS),
      .IdxW (REQ_BITS)
   ) u_rr_arbiter (
      .clk          (clk),
      .reset        (reset),
      .requests     (req_valid),
      .enable       (accept_en),
      .grant_onehot (grant_onehot),
      .grant_index  (grant_index),
      .grant_valid  (grant_valid)
   );

   // Only a register feeds accept_en, so req_ready never sees wb_ready combinationally.
   assign accept_en = !skid_valid_q;
   assign accept    = accept_en && grant_valid;
   assign handshake = main_valid_q && wb_ready;
   assign req_ready = (accept_en && !reset) ? grant_onehot : '0;

   always_comb begin
      sel_payload = '0;
      for (int i = 0; i < int'(NUM_REQS); i++) begin
         if (grant_onehot[i]) begin
            sel_payload = {req_wid[i*NW_BITS +: NW_BITS], req_tmask[i*NUM_THREADS +: NUM_THREADS],
                           req_PC[i*32 +: 32], req_rd[i*NR_BITS +: NR_BITS], req_wb[i],
                           req_data[i*DW +: DW]};
         end
      end
   end

   assign new_entry = {grant_index, sel_payload};

   always_comb begin
      main_valid_d = main_valid_q;
      main_d       = main_q;
      skid_valid_d = skid_valid_q;
      skid_d       = skid_q;
      if (handshake) begin
         main_valid_d = skid_valid_q;
         main_d       = skid_q;
         skid_valid_d = 1'b0;
      end
      if (accept) begin
         if (main_valid_d) begin
            skid_valid_d = 1'b1;
            skid_d       = new_entry;
         end else begin
            main_valid_d = 1'b1;
            main_d       = new_entry;
         end
      end
   end

   always_comb begin
      perf_d = perf_q;
      if (|req_valid && !accept_en) begin
         perf_d = perf_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_q       <= '0;
         skid_q       <= '0;
         perf_q       <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_q       <= main_d;
         skid_q       <= skid_d;
         perf_q       <= perf_d;
      end
   end

   assign wb_valid    = main_valid_q;
   assign {wb_src, wb_wid, wb_tmask, wb_PC, wb_rd, wb_wb, wb_data} = main_q;
   assign perf_stalls = perf_q;

endmodule

// File: tb/tb_vx_commit_arbiter.sv
// Randomized bench for vx_commit_arbiter against a queue-based commit model,
// plus directed reset, contention, backpressure and pointer-skip scenarios.
module tb_vx_commit_arbiter;
   import vx_commit_arbiter_pkg::*;

   localparam int N  = 5;
   localparam int NT = 4;
   localparam int NW = 2;
   localparam int NR = 6;
   localparam int RB = 3;

   typedef struct packed {
      logic [RB-1:0]    src;
      logic [NW-1:0]    wid;
      logic [NT-1:0]    tmask;
      logic [31:0]      pc;
      logic [NR-1:0]    rd;
      logic             wb;
      logic [NT*32-1:0] data;
   } commit_t;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      req_valid, req_ready, req_wb;
   logic [N*NW-1:0]   req_wid;
   logic [N*NT-1:0]   req_tmask;
   logic [N*32-1:0]   req_PC;
   logic [N*NR-1:0]   req_rd;
   logic [N*NT*32-1:0] req_data;
   logic              wb_valid, wb_ready, wb_wb;
   logic [RB-1:0]     wb_src;
   logic [NW-1:0]     wb_wid;
   logic [NT-1:0]     wb_tmask;
   logic [31:0]       wb_PC, perf_stalls;
   logic [NR-1:0]     wb_rd;
   logic [NT*32-1:0]  wb_data;

   vx_commit_arbiter dut (
      .clk (clk), .reset (reset),
      .req_valid (req_valid), .req_ready (req_ready), .req_wid (req_wid),
      .req_tmask (req_tmask), .req_PC (req_PC), .req_rd (req_rd), .req_wb (req_wb),
      .req_data (req_data),
      .wb_valid (wb_valid), .wb_ready (wb_ready), .wb_src (wb_src), .wb_wid (wb_wid),
      .wb_tmask (wb_tmask), .wb_PC (wb_PC), .wb_rd (wb_rd), .wb_wb (wb_wb),
      .wb_data (wb_data), .perf_stalls (perf_stalls)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Requester sources: each holds its item until the model says it was taken.
   commit_t      src_item[N];
   bit           src_valid[N];
   bit [31:0]    pc_ctr[N];
   logic [N-1:0] en_mask;
   int           p_valid, p_ready;

   // Reference model: commits waiting for the sink, in acceptance order (max 2).
   commit_t   mq[$];
   int        ptr;
   bit [31:0] exp_stalls;
   int        s_win;
   bit        s_acc_en, s_wbr, s_any;
   int        dut_grants[$];

   function automatic commit_t new_item(input int i);
      commit_t c;
      c.src   = RB'(i);
      c.wid   = NW'($urandom);
      c.tmask = NT'($urandom);
      c.pc    = pc_ctr[i];
      c.rd    = NR'($urandom);
      c.wb    = 1'($urandom);
      c.data  = {$urandom, $urandom, $urandom, $urandom};
      pc_ctr[i] = pc_ctr[i] + 32'd4;
      return c;
   endfunction

   task automatic flush_sources();
      for (int i = 0; i < N; i++) begin
         src_valid[i] = 1'b0;
         pc_ctr[i]    = 32'h100 + 32'(i) * 32'h1000;
      end
   endtask

   task automatic refresh();
      for (int i = 0; i < N; i++) begin
         if (!src_valid[i] && en_mask[i] && ($urandom_range(99) < p_valid)) begin
            src_item[i]  = new_item(i);
            src_valid[i] = 1'b1;
         end
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i]              = src_valid[i];
         req_wid[i*NW +: NW]       = src_item[i].wid;
         req_tmask[i*NT +: NT]     = src_item[i].tmask;
         req_PC[i*32 +: 32]        = src_item[i].pc;
         req_rd[i*NR +: NR]        = src_item[i].rd;
         req_wb[i]                 = src_item[i].wb;
         req_data[i*NT*32 +: NT*32] = src_item[i].data;
      end
   endtask

   task automatic set_phase(input logic [N-1:0] mask, input int pv, input int pr);
      en_mask = mask;
      p_valid = pv;
      p_ready = pr;
      refresh();
      wb_ready = ($urandom_range(99) < p_ready);
      drive();
   endtask

   task automatic model_clear();
      mq.delete();
      ptr        = 0;
      exp_stalls = 0;
   endtask

   function automatic int winner();
      for (int k = 0; k < N; k++) begin
         if (src_valid[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic compare();
      logic [N-1:0] exp_ready;
      s_acc_en  = (mq.size() < 2);
      s_win     = winner();
      s_wbr     = wb_ready;
      s_any     = |req_valid;
      exp_ready = (s_acc_en && s_win >= 0) ? N'(1 << s_win) : '0;
      check("req_ready", req_ready, exp_ready);
      check("wb_valid", wb_valid, mq.size() > 0);
      if (mq.size() > 0) begin
         check("wb_payload", {wb_src, wb_wid, wb_tmask, wb_PC, wb_rd, wb_wb, wb_data}, mq[0]);
      end
      check("perf_stalls", perf_stalls, exp_stalls);
      for (int i = 0; i < N; i++) if (req_ready[i]) dut_grants.push_back(i);
   endtask

   task automatic update();
      if (mq.size() > 0 && s_wbr) void'(mq.pop_front());
      if (s_acc_en && s_win >= 0) begin
         mq.push_back(src_item[s_win]);
         src_valid[s_win] = 1'b0;
         ptr = (s_win + 1) % N;
      end
      if (s_any && !s_acc_en) exp_stalls = exp_stalls + 32'd1;
   endtask

   task automatic cycle();
      @(negedge clk);
      compare();
      @(posedge clk);
      update();
      #1;
      refresh();
      wb_ready = ($urandom_range(99) < p_ready);
      drive();
   endtask

   int          cnt[N];
   bit [31:0]   s0;
   logic [23:0] seq;

   initial begin
      reset = 1'b1;
      wb_ready = 1'b1;
      flush_sources();
      model_clear();

      // Reset with every requester valid, then idle.
      set_phase('1, 100, 100);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", req_ready, 0);
      check("rst_wb_valid", wb_valid, 0);
      @(posedge clk);
      #1;
      flush_sources();
      set_phase('0, 100, 100);
      reset = 1'b0;
      repeat (2) cycle();

      // Single requester streaming.
      set_phase(N'(1 << EX_ALU), 100, 100);
      repeat (8) cycle();

      // Full contention: fairness over 10 consecutive grants.
      dut_grants.delete();
      set_phase('1, 100, 100);
      repeat (15) cycle();
      check("fair_len", dut_grants.size(), 15);
      for (int i = 0; i < N; i++) cnt[i] = 0;
      for (int k = 0; k < 10 && k < dut_grants.size(); k++) cnt[dut_grants[k]]++;
      for (int i = 0; i < N; i++) check("fair_count", cnt[i], 2);

      // Backpressure from an empty buffer.
      set_phase('0, 100, 100);
      repeat (8) cycle();
      set_phase('1, 100, 0);
      s0 = perf_stalls;
      dut_grants.delete();
      repeat (4) cycle();
      check("bp_grants", dut_grants.size(), 2);
      check("bp_stalls", perf_stalls - s0, 2);
      set_phase('1, 100, 100);
      repeat (6) cycle();

      // Pointer skip: park ptr at CSR, stream CSR/LSU, then FPU shows up.
      flush_sources();
      set_phase('0, 100, 100);
      reset = 1'b1;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      set_phase(N'(1 << EX_LSU), 100, 100);
      cycle();
      dut_grants.delete();
      set_phase(N'((1 << EX_LSU) | (1 << EX_CSR)), 100, 100);
      repeat (5) cycle();
      set_phase(N'((1 << EX_LSU) | (1 << EX_CSR) | (1 << EX_FPU)), 100, 100);
      cycle();
      seq = '1;
      for (int k = 0; k < 6; k++) begin
         if (k < dut_grants.size()) seq[(5 - k)*4 +: 4] = 4'(dut_grants[k]);
      end
      check("skip_order", seq, 24'h212123);

      // Reset while the buffer is full and stalled.
      set_phase('1, 100, 0);
      repeat (4) cycle();
      reset = 1'b1;
      #1;
      check("async_wb_valid", wb_valid, 0);
      check("async_req_ready", req_ready, 0);
      flush_sources();
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      set_phase(N'((1 << EX_CSR) | (1 << EX_GPU)), 100, 100);
      reset = 1'b0;
      dut_grants.delete();
      cycle();
      check("post_rst_grant", (dut_grants.size() > 0) ? dut_grants[0] : 7, EX_CSR);

      // Randomized traffic and backpressure.
      repeat (40) begin
         set_phase(N'($urandom), $urandom_range(10, 100), $urandom_range(0, 100));
         repeat (50) cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
